// File: rtl/fwd_hazard_scoreboard.sv
// Forwarding and hazard scoreboard: shadows destination tags for EX and DEPTH
// post-EX stages, picks the youngest forwarding source and raises ID stalls.
module fwd_hazard_scoreboard #(
  parameter int ADDR_W  = 4,
  parameter int NUM_SRC = 3,
  parameter int DEPTH   = 2,
  localparam int SEL_W  = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      forwarding_enable,
  input  logic                      freeze,
  input  logic                      flush,
  input  logic                      id_valid,
  input  logic [NUM_SRC*ADDR_W-1:0] id_src,
  input  logic [NUM_SRC-1:0]        id_src_valid,
  input  logic [ADDR_W-1:0]         id_dest,
  input  logic                      id_wb_en,
  input  logic                      id_mem_read,
  output logic [NUM_SRC*SEL_W-1:0]  src_select,
  output logic                      hazard_stall,
  output logic [15:0]               stall_count
);

  logic                      r_exValid;
  logic                      r_exWbEn;
  logic                      r_exMemRead;
  logic [ADDR_W-1:0]         r_exDest;
  logic [NUM_SRC*ADDR_W-1:0] r_exSrc;
  logic [NUM_SRC-1:0]        r_exSrcValid;

  // Load flags are only consulted in EX, so the post-EX stages do not carry them.
  logic [DEPTH-1:0]          r_stgValid;
  logic [DEPTH-1:0]          r_stgWbEn;
  logic [ADDR_W-1:0]         r_stgDest [DEPTH];

  logic [15:0]               r_stallCount;
  logic [NUM_SRC*SEL_W-1:0]  w_srcSelect;
  logic                      w_hazard;
  logic                      w_loadEx;

  always_comb begin
    w_srcSelect = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      // Walk oldest to youngest so the lowest matching stage is the one kept.
      for (int j = DEPTH - 1; j >= 0; j--) begin
        if (forwarding_enable && r_exValid && r_exSrcValid[i] &&
            r_stgValid[j] && r_stgWbEn[j] &&
            (r_stgDest[j] == r_exSrc[i*ADDR_W +: ADDR_W])) begin
          w_srcSelect[i*SEL_W +: SEL_W] = SEL_W'(j + 1);
        end
      end
    end
  end

  always_comb begin
    w_hazard = 1'b0;
    if (id_valid && !flush) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (id_src_valid[i]) begin
          if (r_exValid && r_exWbEn && (r_exDest == id_src[i*ADDR_W +: ADDR_W]) &&
              (r_exMemRead || !forwarding_enable)) begin
            w_hazard = 1'b1;
          end
          // Without forwarding only WB is safe, since the register file writes before it reads.
          if (!forwarding_enable) begin
            for (int j = 0; j < DEPTH - 1; j++) begin
              if (r_stgValid[j] && r_stgWbEn[j] &&
                  (r_stgDest[j] == id_src[i*ADDR_W +: ADDR_W])) begin
                w_hazard = 1'b1;
              end
            end
          end
        end
      end
    end
  end

  assign w_loadEx = id_valid && !w_hazard && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_exValid    <= 1'b0;
      r_exSrcValid <= '0;
      r_stgValid   <= '0;
      r_stallCount <= '0;
    end else if (!freeze) begin
      r_stgValid[0] <= r_exValid;
      r_stgWbEn[0]  <= r_exWbEn;
      r_stgDest[0]  <= r_exDest;
      for (int j = 1; j < DEPTH; j++) begin
        r_stgValid[j] <= r_stgValid[j-1];
        r_stgWbEn[j]  <= r_stgWbEn[j-1];
        r_stgDest[j]  <= r_stgDest[j-1];
      end
      r_exValid    <= w_loadEx;
      r_exWbEn     <= id_wb_en;
      r_exMemRead  <= id_mem_read;
      r_exDest     <= id_dest;
      r_exSrc      <= id_src;
      r_exSrcValid <= w_loadEx ? id_src_valid : '0;
      if (w_hazard && (r_stallCount != 16'hFFFF)) begin
        r_stallCount <= r_stallCount + 16'd1;
      end
    end
  end

  assign src_select   = w_srcSelect;
  assign hazard_stall = w_hazard;
  assign stall_count  = r_stallCount;

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Directed bench for fwd_hazard_scoreboard: per-cycle vector table on a DEPTH=2
// instance plus a long forced-stall run on a DEPTH=4 instance for saturation.
module tb_fwd_hazard_scoreboard;

  typedef struct {
    logic        rst, fe, frz, fl, v;
    logic [3:0]  s0, s1, s2;
    logic [2:0]  sv;
    logic [3:0]  d;
    logic        wb, mr;
    logic [1:0]  e0, e1, e2;
    logic        eStall;
    logic [15:0] eCnt;
  } vec_t;

  logic        clk;
  logic        rst, forwardingEnable, freeze, flush, idValid, idWbEn, idMemRead;
  logic [11:0] idSrc;
  logic [2:0]  idSrcValid;
  logic [3:0]  idDest;
  logic [5:0]  srcSelect;
  logic        hazardStall;
  logic [15:0] stallCount;

  logic        sRst;
  logic [11:0] sSrc;
  logic [2:0]  sSrcValid;
  logic [8:0]  sSelect;
  logic        sStall;
  logic [15:0] sCount;

  int errors = 0;
  int checks = 0;
  vec_t vecs[$];

  fwd_hazard_scoreboard #(.ADDR_W(4), .NUM_SRC(3), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .forwarding_enable(forwardingEnable), .freeze(freeze),
    .flush(flush), .id_valid(idValid), .id_src(idSrc), .id_src_valid(idSrcValid),
    .id_dest(idDest), .id_wb_en(idWbEn), .id_mem_read(idMemRead),
    .src_select(srcSelect), .hazard_stall(hazardStall), .stall_count(stallCount)
  );

  fwd_hazard_scoreboard #(.ADDR_W(4), .NUM_SRC(3), .DEPTH(4)) satDut (
    .clk(clk), .rst(sRst), .forwarding_enable(1'b0), .freeze(1'b0),
    .flush(1'b0), .id_valid(1'b1), .id_src(sSrc), .id_src_valid(sSrcValid),
    .id_dest(4'd1), .id_wb_en(1'b1), .id_mem_read(1'b0),
    .src_select(sSelect), .hazard_stall(sStall), .stall_count(sCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(int rs, int fe, int frz, int fl, int v,
                              int s0, int s1, int s2, int sv, int d, int wb, int mr,
                              int e0, int e1, int e2, int es, int ec);
    vec_t r;
    r.rst = 1'(rs); r.fe = 1'(fe); r.frz = 1'(frz); r.fl = 1'(fl); r.v = 1'(v);
    r.s0 = 4'(s0); r.s1 = 4'(s1); r.s2 = 4'(s2); r.sv = 3'(sv); r.d = 4'(d);
    r.wb = 1'(wb); r.mr = 1'(mr);
    r.e0 = 2'(e0); r.e1 = 2'(e1); r.e2 = 2'(e2); r.eStall = 1'(es); r.eCnt = 16'(ec);
    return r;
  endfunction

  task automatic applyStimulus(input vec_t v);
    rst = v.rst; forwardingEnable = v.fe; freeze = v.frz; flush = v.fl;
    idValid = v.v; idSrc = {v.s2, v.s1, v.s0}; idSrcValid = v.sv;
    idDest = v.d; idWbEn = v.wb; idMemRead = v.mr;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  initial begin
    applyStimulus(mk(1,1,0,0,0, 0,0,0,0, 0,0,0, 0,0,0,0,0));
    sRst = 1'b1; sSrc = 12'h001; sSrcValid = 3'b001;

    // rst fe frz fl v | s0 s1 s2 sv | d wb mr | e0 e1 e2 stall cnt
    vecs.push_back(mk(0,1,0,0,0, 0, 0,0,3'b000,  0,0,0, 0,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,1, 1, 2,0,3'b011,  3,1,0, 0,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,1, 3, 3,0,3'b011,  5,1,0, 0,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,0, 0, 0,0,3'b000,  0,0,0, 1,1,0,0,0));
    vecs.push_back(mk(0,1,0,0,1, 6, 0,0,3'b001,  2,1,1, 0,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,1, 2, 8,0,3'b011,  7,1,0, 0,0,0,1,0));
    vecs.push_back(mk(0,1,0,0,1, 2, 8,0,3'b011,  7,1,0, 0,0,0,0,1));
    vecs.push_back(mk(0,1,0,0,0, 0, 0,0,3'b000,  0,0,0, 2,0,0,0,1));
    vecs.push_back(mk(0,1,0,0,1, 9, 0,0,3'b001,  4,1,0, 0,0,0,0,1));
    vecs.push_back(mk(0,1,0,0,1,10, 0,0,3'b001,  4,1,0, 0,0,0,0,1));
    vecs.push_back(mk(0,1,0,0,1, 4, 0,0,3'b001, 11,1,0, 0,0,0,0,1));
    vecs.push_back(mk(0,1,0,0,0, 0, 0,0,3'b000,  0,0,0, 1,0,0,0,1));
    vecs.push_back(mk(0,1,0,0,1,12, 0,0,3'b001,  4,1,0, 0,0,0,0,1));
    vecs.push_back(mk(0,1,0,0,1,14, 0,0,3'b001, 13,1,0, 0,0,0,0,1));
    vecs.push_back(mk(0,1,0,0,1, 0, 4,4,3'b110, 15,1,0, 0,0,0,0,1));
    vecs.push_back(mk(0,1,0,0,0, 0, 0,0,3'b000,  0,0,0, 0,2,2,0,1));
    vecs.push_back(mk(0,1,0,0,0, 0, 0,0,3'b000,  0,0,0, 0,0,0,0,1));
    vecs.push_back(mk(0,1,0,0,0, 0, 0,0,3'b000,  0,0,0, 0,0,0,0,1));
    vecs.push_back(mk(0,0,0,0,1, 1, 0,0,3'b001,  3,1,0, 0,0,0,0,1));
    vecs.push_back(mk(0,0,0,0,1, 3, 0,0,3'b001,  5,1,0, 0,0,0,1,1));
    vecs.push_back(mk(0,0,0,0,1, 3, 0,0,3'b001,  5,1,0, 0,0,0,1,2));
    vecs.push_back(mk(0,0,0,0,1, 3, 0,0,3'b001,  5,1,0, 0,0,0,0,3));
    vecs.push_back(mk(0,0,0,0,0, 0, 0,0,3'b000,  0,0,0, 0,0,0,0,3));
    vecs.push_back(mk(0,1,0,0,1, 1, 0,0,3'b001,  6,1,0, 0,0,0,0,3));
    vecs.push_back(mk(0,1,0,0,1, 6, 0,0,3'b001,  7,1,0, 0,0,0,0,3));
    vecs.push_back(mk(0,0,0,0,0, 0, 0,0,3'b000,  0,0,0, 0,0,0,0,3));
    vecs.push_back(mk(0,0,0,0,1, 0, 0,6,3'b100,  8,1,0, 0,0,0,0,3));
    vecs.push_back(mk(0,1,0,0,0, 0, 0,0,3'b000,  0,0,0, 0,0,0,0,3));
    vecs.push_back(mk(0,1,0,0,1, 6, 0,0,3'b001,  2,1,1, 0,0,0,0,3));
    vecs.push_back(mk(0,1,0,1,1, 2, 0,0,3'b001,  7,1,0, 0,0,0,0,3));
    vecs.push_back(mk(0,0,0,0,1, 7, 0,0,3'b001,  9,1,0, 0,0,0,0,3));
    vecs.push_back(mk(0,1,0,0,0, 0, 0,0,3'b000,  0,0,0, 0,0,0,0,3));
    vecs.push_back(mk(0,1,0,0,1, 9, 0,0,3'b001,  4,1,1, 0,0,0,0,3));
    vecs.push_back(mk(0,1,1,0,1, 4, 0,0,3'b001, 10,1,0, 2,0,0,1,3));
    vecs.push_back(mk(0,1,1,0,1, 4, 0,0,3'b001, 10,1,0, 2,0,0,1,3));
    vecs.push_back(mk(0,1,1,0,1, 4, 0,0,3'b001, 10,1,0, 2,0,0,1,3));
    vecs.push_back(mk(0,1,0,0,1, 4, 0,0,3'b001, 10,1,0, 2,0,0,1,3));
    vecs.push_back(mk(0,1,0,0,1, 4, 0,0,3'b001, 10,1,0, 0,0,0,0,4));
    vecs.push_back(mk(0,1,0,0,0, 0, 0,0,3'b000,  0,0,0, 2,0,0,0,4));
    vecs.push_back(mk(0,1,0,0,1, 0, 0,0,3'b001,  5,1,1, 0,0,0,0,4));
    vecs.push_back(mk(0,1,0,1,1, 5, 0,0,3'b001, 11,1,0, 0,0,0,0,4));
    vecs.push_back(mk(0,0,0,0,1,11, 0,0,3'b001, 12,1,0, 0,0,0,0,4));
    vecs.push_back(mk(0,1,0,0,1, 2, 0,0,3'b001,  1,1,0, 0,0,0,0,4));
    vecs.push_back(mk(0,1,0,0,1, 1, 0,0,3'b001,  1,1,0, 0,0,0,0,4));
    vecs.push_back(mk(0,1,0,0,1, 1, 0,0,3'b001,  1,1,1, 1,0,0,0,4));
    vecs.push_back(mk(1,1,1,0,1, 1, 1,1,3'b111,  2,1,0, 1,0,0,1,4));
    vecs.push_back(mk(0,1,0,0,1, 1, 1,1,3'b111,  2,1,0, 0,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,0, 0, 0,0,3'b000,  0,0,0, 0,0,0,0,0));

    repeat (2) @(negedge clk);
    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      applyStimulus(vecs[k]);
      #1;
      checkOutput($sformatf("vec%0d select", k), 32'(srcSelect),
                  32'({vecs[k].e2, vecs[k].e1, vecs[k].e0}));
      checkOutput($sformatf("vec%0d stall", k), 32'(hazardStall), 32'(vecs[k].eStall));
      checkOutput($sformatf("vec%0d count", k), 32'(stallCount), 32'(vecs[k].eCnt));
    end

    // DEPTH=4, no forwarding, ADD R1<-R1 held in ID: stalls 4 of every 5 cycles.
    begin
      int expCnt = 0;
      int patternErr = 0;
      int countErr = 0;
      logic expStall;
      @(negedge clk);
      sRst = 1'b0;
      for (int c = 0; c < 81930; c++) begin
        #1;
        expStall = (c >= 1) && (((c - 1) % 5) < 4);
        if (sCount !== 16'(expCnt)) countErr++;
        if (sStall !== expStall || sSelect !== 9'd0) patternErr++;
        if (expStall && expCnt < 65535) expCnt++;
        @(negedge clk);
      end
      checkOutput("sat stall pattern mismatches", patternErr, 0);
      checkOutput("sat count track mismatches", countErr, 0);
      checkOutput("sat final count", 32'(sCount), 32'h0000FFFF);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
